// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - mode encodings and polarity-aware one-hot decode helper
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT   = 1 << MAX_SEL_W;

    // Callers slice the low 2**SEL_W bits of the result.
    function automatic logic [MAX_OUT-1:0] onehot_decode(
        input logic [MAX_SEL_W-1:0] idx,
        input logic                 active_low
    );
        logic [MAX_OUT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - scan step prescaler: counts while running, ticks when count reaches div
module scan_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        // >= rather than == so that lowering div below the running count ticks at once
        tick  = run && (cnt_q >= div);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered enable-gated N-way decoder with direct and auto-scan modes
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  g1,
    input  logic                  g2a_n,
    input  logic                  g2b_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [SEL_W-1:0]      scan_last,
    input  logic [DIV_W-1:0]      div,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  wrap
);

    localparam int OUT_N = 2**SEL_W;

    logic                 en;
    logic                 scan_entry;
    logic                 presc_clear;
    logic                 presc_run;
    logic                 tick;
    logic [MAX_OUT-1:0]   dec;

    logic                 mode_q, mode_d;
    logic [SEL_W-1:0]     index_q, index_d;
    logic [OUT_N-1:0]     y_q, y_d;
    logic [SEL_W-1:0]     cur_sel_q, cur_sel_d;
    logic                 wrap_q, wrap_d;

    scan_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (presc_clear),
        .run   (presc_run),
        .div   (div),
        .tick  (tick)
    );

    always_comb begin
        en          = g1 & ~g2a_n & ~g2b_n;
        scan_entry  = (mode == MODE_SCAN) && (mode_q == MODE_DIRECT);
        // Entry clear applies even with the enables off, so scanning always starts at channel 0.
        presc_clear = scan_entry || ((mode == MODE_DIRECT) && en);
        presc_run   = (mode == MODE_SCAN) && (mode_q == MODE_SCAN) && en;
        mode_d      = mode;

        index_d = index_q;
        wrap_d  = 1'b0;
        if (presc_clear) begin
            index_d = '0;
        end else if (tick) begin
            if (index_q >= scan_last) begin
                index_d = '0;
                wrap_d  = 1'b1;
            end else begin
                index_d = index_q + SEL_W'(1);
            end
        end

        dec       = '0;
        y_d       = {OUT_N{ACTIVE_LOW}};
        cur_sel_d = cur_sel_q;
        if (en) begin
            cur_sel_d = (mode == MODE_SCAN) ? index_d : sel;
            dec       = onehot_decode(MAX_SEL_W'(cur_sel_d), ACTIVE_LOW);
            y_d       = dec[OUT_N-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_DIRECT;
            index_q   <= '0;
            y_q       <= {OUT_N{ACTIVE_LOW}};
            cur_sel_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            index_q   <= index_d;
            y_q       <= y_d;
            cur_sel_q <= cur_sel_d;
            wrap_q    <= wrap_d;
        end
    end

    assign y       = y_q;
    assign cur_sel = cur_sel_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - self-checking bench for scan_decoder (default build plus 4-bit active-high build)
module tb_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        g1, g2a_n, g2b_n, mode;
    logic [2:0]  sel, scan_last;
    logic [15:0] div;
    logic [7:0]  y_a;
    logic [2:0]  cur_sel_a;
    logic        wrap_a;

    logic [3:0]  sel_b, scan_last_b;
    logic [15:0] div_b;
    logic [15:0] y_b;
    logic [3:0]  cur_sel_b;
    logic        wrap_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1), .DIV_W(16)) dut_a (
        .clk(clk), .rst(rst), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n), .mode(mode),
        .sel(sel), .scan_last(scan_last), .div(div),
        .y(y_a), .cur_sel(cur_sel_a), .wrap(wrap_a)
    );

    scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b0), .DIV_W(16)) dut_b (
        .clk(clk), .rst(rst), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n), .mode(mode),
        .sel(sel_b), .scan_last(scan_last_b), .div(div_b),
        .y(y_b), .cur_sel(cur_sel_b), .wrap(wrap_b)
    );

    typedef struct {
        string       tag;
        logic        dut_b;
        logic [15:0] y;
        logic [3:0]  cs;
        logic        wrap;
    } exp_t;

    typedef struct {
        logic       g1, g2a_n, g2b_n;
        logic [2:0] sel;
        logic [7:0] y;
        logic [2:0] cs;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t ex_a(input string tag, input int chan, input int cs, input bit w);
        exp_t       e;
        logic [7:0] v;
        v      = (chan < 0) ? 8'h00 : (8'h01 << chan);
        e.tag  = tag;
        e.dut_b = 1'b0;
        e.y    = {8'h00, ~v};
        e.cs   = 4'(cs);
        e.wrap = w;
        return e;
    endfunction

    function automatic exp_t ex_b(input string tag, input int chan, input int cs, input bit w);
        exp_t e;
        e.tag  = tag;
        e.dut_b = 1'b1;
        e.y    = (chan < 0) ? 16'h0000 : (16'h0001 << chan);
        e.cs   = 4'(cs);
        e.wrap = w;
        return e;
    endfunction

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        if (!e.dut_b) begin
            chk({e.tag, ".y"},       32'(y_a),       32'(e.y[7:0]));
            chk({e.tag, ".cur_sel"}, 32'(cur_sel_a), 32'(e.cs[2:0]));
            chk({e.tag, ".wrap"},    32'(wrap_a),    32'(e.wrap));
        end else begin
            chk({e.tag, ".y"},       32'(y_b),       32'(e.y));
            chk({e.tag, ".cur_sel"}, 32'(cur_sel_b), 32'(e.cs));
            chk({e.tag, ".wrap"},    32'(wrap_b),    32'(e.wrap));
        end
    endtask

    task automatic cycle(input exp_t e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    function automatic int chan_of(input int k, input int period, input int nch);
        return (k / period) % nch;
    endfunction

    function automatic bit wrap_of(input int k, input int period, input int nch);
        return (k > 0) && (k % period == 0) && (chan_of(k, period, nch) == 0);
    endfunction

    task automatic to_direct(input logic [2:0] s);
        mode = 1'b0;
        sel  = s;
        cycle(ex_a("to_direct", int'(s), int'(s), 1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] dis [7];
        int         k;

        dis = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 1'b0, 1'b0, 3'(i), ~(8'h01 << i), 3'(i)};
        end
        for (int j = 0; j < 7; j++) begin
            tbl[8 + j] = '{dis[j][2], dis[j][1], dis[j][0], 3'(j), 8'hFF, 3'd7};
        end

        rst = 1'b1; g1 = 1'b0; g2a_n = 1'b1; g2b_n = 1'b1; mode = 1'b0;
        sel = '0; scan_last = 3'd7; div = '0;
        sel_b = '0; scan_last_b = 4'd15; div_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.y", 32'(y_a), 32'hFF);
        chk("reset.cur_sel", 32'(cur_sel_a), 0);
        chk("reset.wrap", 32'(wrap_a), 0);
        rst = 1'b0;

        // direct sweep and every disabled enable combination
        for (int i = 0; i < 15; i++) begin
            exp_t e;
            g1 = tbl[i].g1; g2a_n = tbl[i].g2a_n; g2b_n = tbl[i].g2b_n; sel = tbl[i].sel;
            e = ex_a($sformatf("direct%0d", i), 0, int'(tbl[i].cs), 1'b0);
            e.y = {8'h00, tbl[i].y};
            cycle(e);
        end

        g1 = 1'b1; g2a_n = 1'b0; g2b_n = 1'b0;
        to_direct(3'd0);

        // scan div=2, scan_last=7
        div = 16'd2; scan_last = 3'd7; mode = 1'b1;
        for (k = 0; k <= 26; k++) begin
            cycle(ex_a("scan3", chan_of(k, 3, 8), chan_of(k, 3, 8), wrap_of(k, 3, 8)));
        end
        to_direct(3'd0);

        // div=0, scan_last=3 then 0
        div = 16'd0; scan_last = 3'd3; mode = 1'b1;
        for (k = 0; k <= 9; k++) begin
            cycle(ex_a("scan_l3", chan_of(k, 1, 4), chan_of(k, 1, 4), wrap_of(k, 1, 4)));
        end
        scan_last = 3'd0;
        for (int j = 0; j < 4; j++) begin
            cycle(ex_a("scan_l0", 0, 0, 1'b1));
        end

        // asynchronous reset between edges while wrap is high
        #3 rst = 1'b1;
        #1;
        chk("async_rst.y", 32'(y_a), 32'hFF);
        chk("async_rst.cur_sel", 32'(cur_sel_a), 0);
        chk("async_rst.wrap", 32'(wrap_a), 0);
        mode = 1'b0; sel = 3'd2;
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(ex_a("post_rst", 2, 2, 1'b0));
        to_direct(3'd0);

        // hold: g1 low for 5 clocks at index 5
        div = 16'd2; scan_last = 3'd7; mode = 1'b1;
        for (k = 0; k <= 16; k++) begin
            cycle(ex_a("hold_pre", chan_of(k, 3, 8), chan_of(k, 3, 8), wrap_of(k, 3, 8)));
        end
        g1 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle(ex_a("hold", -1, 5, 1'b0));
        end
        g1 = 1'b1;
        for (k = 17; k <= 26; k++) begin
            cycle(ex_a("hold_post", chan_of(k, 3, 8), chan_of(k, 3, 8), wrap_of(k, 3, 8)));
        end
        to_direct(3'd0);

        // lowering scan_last below the index at index 6
        div = 16'd2; scan_last = 3'd7; mode = 1'b1;
        for (k = 0; k <= 18; k++) begin
            cycle(ex_a("lower_pre", chan_of(k, 3, 8), chan_of(k, 3, 8), wrap_of(k, 3, 8)));
        end
        scan_last = 3'd2;
        cycle(ex_a("lower_k19", 6, 6, 1'b0));
        cycle(ex_a("lower_k20", 6, 6, 1'b0));
        cycle(ex_a("lower_k21", 0, 0, 1'b1));
        cycle(ex_a("lower_k22", 0, 0, 1'b0));
        cycle(ex_a("lower_k23", 0, 0, 1'b0));
        cycle(ex_a("lower_k24", 1, 1, 1'b0));
        to_direct(3'd4);

        // lowering div from 100 to 1 with the prescaler at 50
        div = 16'd100; scan_last = 3'd7; mode = 1'b1;
        for (k = 0; k <= 50; k++) begin
            cycle(ex_a("div100", 0, 0, 1'b0));
        end
        div = 16'd1;
        cycle(ex_a("div1_k51", 1, 1, 1'b0));
        cycle(ex_a("div1_k52", 1, 1, 1'b0));
        cycle(ex_a("div1_k53", 2, 2, 1'b0));
        to_direct(3'd4);

        // scan entry while disabled: outputs inactive, cur_sel holds, entry clear still applies
        div = 16'd2; g1 = 1'b0; mode = 1'b1;
        cycle(ex_a("entry_dis", -1, 4, 1'b0));
        g1 = 1'b1;
        cycle(ex_a("entry_after", 0, 0, 1'b0));
        to_direct(3'd0);

        // 4-bit active-high build: 16-line direct sweep
        for (int i = 0; i < 16; i++) begin
            sel_b = 4'(i);
            cycle(ex_b($sformatf("b_direct%0d", i), i, i, 1'b0));
        end
        g2a_n = 1'b1;
        cycle(ex_b("b_disabled", -1, 15, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
